// File: rtl/tpu_host_seq.sv
// Host-side sequencer: streams A and B rows into tpuv1, issues MatMul, waits, then streams C half-rows out.
// Define TPU_HOST_CPRELOAD_EN to add a CPRE state that preloads the accumulator (bias) before MatMul.
module tpu_host_seq #(
  parameter int DIM         = 8,
  parameter int ADDRW       = 16,
  parameter int DATAW       = 64,
  parameter int WAIT_CYCLES = 3*DIM+2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  output logic             tpu_r_w,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  localparam int NHALF = 2*DIM;
  localparam int KW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int JW    = $clog2(NHALF + 1);
  localparam int TW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  localparam logic [ADDRW-1:0] A_BASE   = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE   = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE   = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] CMD_ADDR = ADDRW'(16'h0400);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_CPRE, S_MATMUL, S_WAIT, S_READ_C
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [JW-1:0]    j_q, j_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [DATAW-1:0] out_data_q, out_data_d;
  logic             in_hs;

`ifdef TPU_HOST_CPRELOAD_EN
  assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_CPRE);
`else
  assign in_ready = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
`endif
  assign in_hs     = in_valid & in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

  // The bus defaults to the idle pattern (read of 0x0000); only handshakes produce writes.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    j_d         = j_q;
    timer_d     = timer_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    tpu_r_w     = 1'b0;
    tpu_addr    = '0;
    tpu_wdata   = '0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          k_d     = '0;
        end
      end
      S_LOAD_A: begin
        if (in_hs) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = A_BASE + (ADDRW'(k_q) << 3);
          tpu_wdata = in_data;
          if (k_q == KW'(DIM-1)) begin
            state_d = S_LOAD_B;
            k_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (in_hs) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = B_BASE + (ADDRW'(k_q) << 3);
          tpu_wdata = in_data;
          if (k_q == KW'(DIM-1)) begin
`ifdef TPU_HOST_CPRELOAD_EN
            state_d = S_CPRE;
            j_d     = '0;
`else
            state_d = S_MATMUL;
`endif
            k_d = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
`ifdef TPU_HOST_CPRELOAD_EN
      S_CPRE: begin
        if (in_hs) begin
          tpu_r_w   = 1'b1;
          tpu_addr  = C_BASE + (ADDRW'(j_q) << 3);
          tpu_wdata = in_data;
          if (j_q == JW'(NHALF-1)) begin
            state_d = S_MATMUL;
            j_d     = '0;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
      end
`endif
      S_MATMUL: begin
        tpu_addr = CMD_ADDR;
        state_d  = S_WAIT;
        timer_d  = '0;
      end
      S_WAIT: begin
        if (timer_q == TW'(WAIT_CYCLES-1)) begin
          state_d = S_READ_C;
          j_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_READ_C: begin
        // Half-row j lives at C_BASE + 8*j; once all are captured the bus goes idle.
        if (j_q != JW'(NHALF)) begin
          tpu_addr = C_BASE + (ADDRW'(j_q) << 3);
        end
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done        = 1'b1;
          state_d     = S_IDLE;
          j_d         = '0;
        end else if ((!out_valid_q || out_ready) && (j_q != JW'(NHALF))) begin
          out_data_d  = tpu_rdata;
          out_valid_d = 1'b1;
          out_last_d  = (j_q == JW'(NHALF-1));
          j_d         = j_q + JW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      j_q         <= '0;
      timer_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      j_q         <= j_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Self-checking bench for tpu_host_seq with a behavioural tpuv1 port model and write/readback scoreboards.
// Honours TPU_HOST_CPRELOAD_EN to expect the bias preload words and C writes.
module tb_tpu_host_seq;

  localparam int DIM         = 8;
  localparam int ADDRW       = 16;
  localparam int DATAW       = 64;
  localparam int WAIT_CYCLES = 3*DIM+2;
  localparam int NHALF       = 2*DIM;
`ifdef TPU_HOST_CPRELOAD_EN
  localparam int WORDS = 4*DIM;
`else
  localparam int WORDS = 2*DIM;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             out_last;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  tpu_host_seq #(.DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] addr; logic [63:0] data; } wr_t;
  typedef struct packed { logic last; logic [63:0] data; } out_t;

  wr_t  exp_wr[$];
  out_t exp_out[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int rd_idx = 0, out_seen = 0, mm_count = 0, mm_cyc = 0, first_rd_cyc = 0, wr_count = 0;
  int first_hs_cyc = 0, last_hs_cyc = 0;
  logic [15:0] last_rd_addr = '0;
  logic        stalled_prev = 1'b0;
  logic [63:0] held_data = '0;

  logic [63:0] a_mem [DIM];
  logic [63:0] b_mem [DIM];
  logic [63:0] bias_mem [NHALF];
  logic [63:0] c_mem [NHALF];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // tpuv1 model: MatMul computes C = bias + A*B and consumes the bias; contents survive host reset.
  initial begin
    int sum;
    for (int i = 0; i < DIM; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    for (int i = 0; i < NHALF; i++) begin bias_mem[i] = '0; c_mem[i] = '0; end
    forever begin
      @(negedge clk);
      if (tpu_r_w) begin
        if (tpu_addr >= 16'h0100 && tpu_addr < 16'(16'h0100 + 8*DIM))
          a_mem[int'(tpu_addr - 16'h0100) >> 3] = tpu_wdata;
        else if (tpu_addr >= 16'h0200 && tpu_addr < 16'(16'h0200 + 8*DIM))
          b_mem[int'(tpu_addr - 16'h0200) >> 3] = tpu_wdata;
        else if (tpu_addr >= 16'h0300 && tpu_addr < 16'(16'h0300 + 8*NHALF))
          bias_mem[int'(tpu_addr - 16'h0300) >> 3] = tpu_wdata;
      end else if (tpu_addr == 16'h0400) begin
        for (int r = 0; r < DIM; r++) begin
          for (int i = 0; i < DIM; i++) begin
            sum = int'(bias_mem[2*r + i/4][16*(i%4) +: 16]);
            for (int k = 0; k < DIM; k++)
              sum += int'(a_mem[r][8*k +: 8]) * int'(b_mem[k][8*i +: 8]);
            c_mem[2*r + i/4][16*(i%4) +: 16] = 16'(sum);
          end
        end
        for (int i = 0; i < NHALF; i++) bias_mem[i] = '0;
      end
    end
  end

  always_comb begin
    tpu_rdata = '0;
    if (tpu_addr >= 16'h0300 && tpu_addr < 16'(16'h0300 + 8*NHALF))
      tpu_rdata = c_mem[int'(tpu_addr - 16'h0300) >> 3];
  end

  // Passive monitor: pops the write and readback scoreboards as the DUT produces bus/stream activity.
  initial begin
    wr_t  w;
    out_t o;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled_prev = 1'b0;
      end else begin
        if (tpu_r_w) begin
          wr_count++;
          checks++;
          if (!(in_valid && in_ready)) begin
            errors++;
            $display("[TB] FAIL wr_without_handshake addr=%h in_valid=%b in_ready=%b", tpu_addr, in_valid, in_ready);
          end
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write addr=%h data=%h", tpu_addr, tpu_wdata);
          end else begin
            w = exp_wr.pop_front();
            if (tpu_addr !== w.addr || tpu_wdata !== w.data) begin
              errors++;
              $display("[TB] FAIL wr_word got addr=%h data=%h expected addr=%h data=%h", tpu_addr, tpu_wdata, w.addr, w.data);
            end
          end
        end
        if (!tpu_r_w && tpu_addr == 16'h0400) begin
          mm_count++;
          mm_cyc = cyc;
          checks++;
          if (exp_wr.size() != 0) begin
            errors++;
            $display("[TB] FAIL matmul_before_writes pending=%0d expected=0", exp_wr.size());
          end
        end
        if (!tpu_r_w && tpu_addr >= 16'h0300 && tpu_addr < 16'(16'h0300 + 8*NHALF) && tpu_addr != last_rd_addr) begin
          if (rd_idx == 0) first_rd_cyc = cyc;
          checks++;
          if (tpu_addr !== 16'(16'h0300 + 8*rd_idx)) begin
            errors++;
            $display("[TB] FAIL rd_addr got=%h expected=%h", tpu_addr, 16'(16'h0300 + 8*rd_idx));
          end
          rd_idx++;
          last_rd_addr = tpu_addr;
        end
        if (stalled_prev) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== held_data) begin
            errors++;
            $display("[TB] FAIL out_hold got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, held_data);
          end
        end
        if (out_valid && out_ready) begin
          out_seen++;
          checks++;
          if (exp_out.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_out data=%h", out_data);
          end else begin
            o = exp_out.pop_front();
            if (out_data !== o.data || out_last !== o.last || done !== o.last) begin
              errors++;
              $display("[TB] FAIL out_word got data=%h last=%b done=%b expected data=%h last=%b done=%b",
                       out_data, out_last, done, o.data, o.last, o.last);
            end
          end
        end else begin
          checks++;
          if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_without_handshake got=%b expected=0", done);
          end
        end
        stalled_prev = out_valid && !out_ready;
        held_data    = out_data;
      end
    end
  end

  task automatic feed_job(input int pat, input bit toggle, input bit hold_start);
    logic [63:0] words [4*DIM];
    int   c_exp [DIM][DIM];
    int   n, pushed, guard, sum;
    bit   phase, hs;
    wr_t  w;
    out_t o;
    for (int r = 0; r < DIM; r++) begin
      if (pat == 0) begin
        words[r]     = 64'h1 << (8*r);
        words[DIM+r] = 64'h0202020202020202;
      end else begin
        for (int e = 0; e < 8; e++) begin
          words[r][8*e +: 8]     = 8'($urandom_range(0, 15));
          words[DIM+r][8*e +: 8] = 8'($urandom_range(0, 15));
        end
      end
    end
    for (int h = 0; h < NHALF; h++) begin
      if (pat == 0) words[2*DIM+h] = 64'h0001000100010001;
      else for (int e = 0; e < 4; e++) words[2*DIM+h][16*e +: 16] = 16'($urandom_range(0, 255));
    end
    for (int r = 0; r < DIM; r++) begin
      for (int i = 0; i < DIM; i++) begin
        sum = 0;
`ifdef TPU_HOST_CPRELOAD_EN
        sum = int'(words[2*DIM + 2*r + i/4][16*(i%4) +: 16]);
`endif
        for (int k = 0; k < DIM; k++) sum += int'(words[r][8*k +: 8]) * int'(words[DIM+k][8*i +: 8]);
        c_exp[r][i] = sum;
      end
    end
    for (int j = 0; j < NHALF; j++) begin
      o.data = '0;
      for (int e = 0; e < 4; e++) o.data[16*e +: 16] = 16'(c_exp[j/2][(j%2)*4 + e]);
      o.last = (j == NHALF-1);
      exp_out.push_back(o);
    end
    rd_idx = 0; last_rd_addr = '0; out_seen = 0; mm_count = 0; wr_count = 0;
    n = 0; pushed = 0; guard = 0; phase = 1'b0;
    start = 1'b1;
    while (n < WORDS && guard < 1000) begin
      if (toggle && phase) begin
        in_valid = 1'b0;
        in_data  = '1;
      end else begin
        if (pushed == n) begin
          w.addr = (n < DIM) ? 16'(16'h0100 + 8*n) : (n < 2*DIM) ? 16'(16'h0200 + 8*(n-DIM)) : 16'(16'h0300 + 8*(n-2*DIM));
          w.data = words[n];
          exp_wr.push_back(w);
          pushed++;
        end
        in_valid = 1'b1;
        in_data  = words[n];
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      if (hs) begin
        if (n == 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        n++;
      end
      @(posedge clk);
      #1;
      if (!hold_start) start = 1'b0;
      phase = !phase;
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != WORDS) begin
      errors++;
      $display("[TB] FAIL feed_timeout accepted=%0d expected=%0d", n, WORDS);
    end
  endtask

  task automatic drain_job(input int stall_at, input int stall_len);
    int guard, stall_cnt, busy_low;
    bit got_done;
    guard = 0; stall_cnt = 0; busy_low = 0; got_done = 1'b0;
    while (!got_done && guard < 3000) begin
      out_ready = !(out_seen >= stall_at && stall_cnt < stall_len);
      if (!out_ready) stall_cnt++;
      @(negedge clk);
      if (!busy) busy_low++;
      if (done) got_done = 1'b1;
      @(posedge clk);
      #1;
      guard++;
    end
    start = 1'b0;
    checks++;
    if (!got_done) begin errors++; $display("[TB] FAIL done_timeout got=0 expected=1"); end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_done got busy=%b out_valid=%b expected 0 0", busy, out_valid);
    end
    checks++;
    if (busy_low != 0) begin errors++; $display("[TB] FAIL busy_dropped got=%0d expected=0", busy_low); end
    checks++;
    if (out_seen != NHALF || exp_out.size() != 0) begin
      errors++;
      $display("[TB] FAIL out_count got=%0d left=%0d expected=%0d left=0", out_seen, exp_out.size(), NHALF);
    end
    checks++;
    if (mm_count != 1 || wr_count != WORDS) begin
      errors++;
      $display("[TB] FAIL job_counts got mm=%0d wr=%0d expected mm=1 wr=%0d", mm_count, wr_count, WORDS);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got busy=%b done=%b in_ready=%b out_valid=%b out_last=%b expected all 0",
               busy, done, in_ready, out_valid, out_last);
    end
    checks++;
    if (out_data !== '0 || tpu_r_w !== 1'b0 || tpu_addr !== '0 || tpu_wdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus got out_data=%h r_w=%b addr=%h wdata=%h expected 0", out_data, tpu_r_w, tpu_addr, tpu_wdata);
    end
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'hDEADBEEFCAFEF00D;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tpu_addr !== '0 || tpu_r_w !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_bus cycle=%0d got addr=%h r_w=%b busy=%b in_ready=%b expected 0", i, tpu_addr, tpu_r_w, busy, in_ready);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    feed_job(0, 1'b0, 1'b0);
    checks++;
    if (last_hs_cyc - first_hs_cyc != WORDS-1) begin
      errors++;
      $display("[TB] FAIL b2b_span got=%0d expected=%0d", last_hs_cyc - first_hs_cyc, WORDS-1);
    end
    drain_job(NHALF, 0);
    checks++;
    if (first_rd_cyc - mm_cyc != WAIT_CYCLES+1) begin
      errors++;
      $display("[TB] FAIL wait_latency got=%0d expected=%0d", first_rd_cyc - mm_cyc, WAIT_CYCLES+1);
    end
  endtask

  task automatic test_toggle();
    feed_job(1, 1'b1, 1'b0);
    checks++;
    if (last_hs_cyc - first_hs_cyc != 2*(WORDS-1)) begin
      errors++;
      $display("[TB] FAIL toggle_span got=%0d expected=%0d", last_hs_cyc - first_hs_cyc, 2*(WORDS-1));
    end
    drain_job(NHALF, 0);
  endtask

  task automatic test_stall();
    feed_job(0, 1'b0, 1'b0);
    drain_job(5, 20);
  endtask

  task automatic test_start_busy();
    feed_job(1, 1'b0, 1'b1);
    drain_job(NHALF, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_after_done got busy=%b expected=0", busy); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_wait();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    feed_job(0, 1'b0, 1'b0);
    while (mm_count == 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    if (mm_count == 0) begin errors++; $display("[TB] FAIL matmul_timeout got=0 expected=1"); end
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || tpu_addr !== '0 || tpu_r_w !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got busy=%b addr=%h r_w=%b in_ready=%b out_valid=%b expected 0",
               busy, tpu_addr, tpu_r_w, in_ready, out_valid);
    end
    exp_out.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got busy=%b expected=0", busy); end
    feed_job(1, 1'b0, 1'b0);
    drain_job(NHALF, 0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle();
    test_stall();
    test_start_busy();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tpu_host_seq.md
Name: tpu_host_seq

Overview:
- Host-side initiator that drives the tpuv1 memory-mapped port (r_w, addr, dataIn, dataOut) through one complete matrix multiply.
- Sequence: accept A rows, then B rows, from an input valid/ready stream and write them into the accelerator. Issue the MatMul command, wait for the systolic pass, then read all C half-rows back onto an output valid/ready stream.
- Sits between a DMA/host FIFO and tpuv1. It is the only master of the accelerator port.

Parameters:
- DIM, 8, systolic array dimension (rows of A, B and C).
- ADDRW, 16, accelerator address width.
- DATAW, 64, data word width (DIM x 8-bit A/B elements; 4 x 16-bit C elements per half-row).
- WAIT_CYCLES, 3*DIM+2, cycles held in WAIT after the MatMul command before reading C.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a job; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the last C word handshakes
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  DATAW  A row, then B row (element i at bits 8i+7:8i)
- out_valid  out  1  C word valid
- out_ready  in  1  downstream accepts C word
- out_data  out  DATAW  C half-row (element i at bits 16i+15:16i)
- out_last  out  1  qualifies the final C word of the job
- tpu_r_w  out  1  0 = read, 1 = write
- tpu_addr  out  ADDRW  accelerator address
- tpu_wdata  out  DATAW  to accelerator dataIn
- tpu_rdata  in  DATAW  from accelerator dataOut (combinational from tpu_addr)

Behaviour:
- Reset values: state IDLE, all counters 0, busy/done/in_ready/out_valid/out_last 0, out_data 0, tpu_r_w 0, tpu_addr 16'h0000, tpu_wdata 0.
- Idle bus: tpu_r_w=0, tpu_addr=16'h0000. This decodes to no operation and must never alias 16'h0400.
- Address map:
  - A row r: 16'h0100 + 8r.
  - B row r: 16'h0200 + 8r.
  - C row r upper half (elements 0-3): 16'h0300 + 16r.
  - C row r lower half (elements 4-7): 16'h0300 + 16r + 8.
  - MatMul command: 16'h0400.
- Write path:
  - in_ready is combinational: 1 in LOAD_A/LOAD_B, else 0.
  - On each input handshake, the same cycle drives tpu_r_w=1, tpu_wdata=in_data, and the address of the current row index k.
  - Cycles without a handshake drive the idle bus. B writes are therefore single-cycle pulses.
- States:
  - IDLE: start=1 -> LOAD_A, k=0.
  - LOAD_A: per handshake k++. On the handshake with k=DIM-1 -> LOAD_B, k=0.
  - LOAD_B: same counting. At k=DIM-1 -> MATMUL (or CPRE, see Optional Feature).
  - MATMUL: exactly one cycle driving tpu_r_w=0, tpu_addr=16'h0400. -> WAIT, timer=0.
  - WAIT: timer++. At timer=WAIT_CYCLES-1 -> READ_C, j=0.
  - READ_C: drives tpu_r_w=0, tpu_addr = C address of half-row j (row j>>1, half j[0]) continuously.
    - When !out_valid || out_ready: out_data <= tpu_rdata, out_valid <= 1, out_last <= (j==2*DIM-1), j++.
    - After j reaches 2*DIM, no further capture.
    - When out_valid & out_ready & out_last: out_valid <= 0, done pulses 1 for one cycle, -> IDLE.
- Output ordering: 2*DIM words, C row 0 upper, row 0 lower, row 1 upper, and so on. out_data is held stable while out_valid & !out_ready.
- Boundaries:
  - start while busy is ignored.
  - in_valid outside LOAD states is ignored (in_ready=0).
  - Back-to-back in_valid gives one write per cycle.
  - out_ready tied low stalls READ_C indefinitely with no bus writes.
  - rst_n low mid-job returns to IDLE asynchronously. Accelerator contents are not cleared.
  - start asserted in the same cycle as done is ignored; a job starts from a start seen in IDLE.

Optional Feature:
- Macro: TPU_HOST_CPRELOAD_EN.
- Defined:
  - Adds state CPRE between LOAD_B and MATMUL.
  - Accepts 2*DIM further input words and writes each with tpu_r_w=1 to the C half-row address of index j, in the same order as readback.
  - This preloads the accumulator (bias). Input per job is 4*DIM words.
- Undefined:
  - LOAD_B goes directly to MATMUL.
  - Input per job is 2*DIM words.
  - No C writes are ever issued.

Test Plan:
- Reset then idle: tpu_addr=0, tpu_r_w=0, busy=0, in_ready=0 for 10 cycles.
- start, 16 words with in_valid always 1 (A=identity rows 64'h01<<8r, B rows all 8'h02):
  - 16 writes at 0x0100..0x0138, then 0x0200..0x0238.
  - One 0x0400 cycle.
  - busy stays high through 26 WAIT cycles.
- Same job with in_valid toggling 1/0: writes occur only on handshake cycles; addresses are still sequential and contiguous.
- Readback with out_ready=1 against the identity result:
  - 16 words, each element 16'h0002.
  - Addresses 0x0300, 0x0308, ..., 0x0378.
  - out_last and done coincide with word 16.
- out_ready held 0 for 20 cycles mid-readback: out_data stable and no word lost or duplicated. Then assert rst_n=0 mid-WAIT: busy=0 immediately and tpu_addr=0.
- With TPU_HOST_CPRELOAD_EN and 16 bias words of 16'h0001 elements:
  - 32 input words consumed, C writes at 0x0300..0x0378 before 0x0400.
  - Readback elements equal 16'h0003.
